// File: rtl/picobello_pkg.sv
// Shared register map and helpers for the tile event-to-interrupt controller.
package picobello_pkg;

   localparam logic [31:0] EvtIrqPendingOffset  = 32'h00;
   localparam logic [31:0] EvtIrqSetOffset      = 32'h04;
   localparam logic [31:0] EvtIrqModeOffset     = 32'h08;
   localparam logic [31:0] EvtIrqMaskBaseOffset = 32'h10;

   typedef enum logic [2:0] {
      EvtIrqRegPending,
      EvtIrqRegSet,
      EvtIrqRegMode,
      EvtIrqRegMask,
      EvtIrqRegInvalid
   } evt_irq_reg_e;

   function automatic logic [31:0] strb_to_bitmask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/tile_evt_edge_det.sv
// Per-event pending latch: edge-captured with SW set/clear, or a level follower.
module tile_evt_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic evt_i,
   input  logic edge_mode_i,
   input  logic set_i,
   input  logic clr_i,
   output logic pending_o
);

   logic evt_q;

   // evt_q resets low, so a line already high at reset release counts as an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         evt_q     <= 1'b0;
         pending_o <= 1'b0;
      end else begin
         evt_q <= evt_i;
         if (edge_mode_i) begin
            pending_o <= (evt_i & ~evt_q) | set_i | (pending_o & ~clr_i);
         end else begin
            pending_o <= evt_i;
         end
      end
   end

endmodule

// File: rtl/tile_evt_irq_ctrl.sv
// Maps accelerator event lines onto masked per-core external interrupts,
// with a small TCDM-style register port (PENDING / SET / MODE / MASK[c]).
module tile_evt_irq_ctrl
   import picobello_pkg::*;
#(
   parameter int unsigned NrCores   = 9,
   parameter int unsigned NrEvents  = 4,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter logic [31:0] ResetMode = '0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NrEvents-1:0]    evt_i,
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic [DataWidth-1:0]   wdata_i,
   input  logic [DataWidth/8-1:0] strb_i,
   output logic                   gnt_o,
   output logic                   rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o,
   output logic [NrCores-1:0]     mxip_o
);

   logic [NrEvents-1:0]  pending;
   logic [NrEvents-1:0]  mode_q;
   logic [NrEvents-1:0]  mask_q [NrCores];
   logic [NrEvents-1:0]  set_sw, clr_sw, bm, wbits;
   logic [31:0]          bitmask32, wdata_m;
   logic [AddrWidth-1:0] off, mask_off, mask_idx;
   logic                 wr_en;
   evt_irq_reg_e         reg_sel;
   logic [DataWidth-1:0] rdata_d;

   assign gnt_o = req_i;
   assign wr_en = req_i & we_i;

   always_comb begin
      off      = addr_i & ~AddrWidth'(3);
      mask_off = off - AddrWidth'(EvtIrqMaskBaseOffset);
      mask_idx = mask_off >> 2;
      reg_sel  = EvtIrqRegInvalid;
      if (off == AddrWidth'(EvtIrqPendingOffset)) begin
         reg_sel = EvtIrqRegPending;
      end else if (off == AddrWidth'(EvtIrqSetOffset)) begin
         reg_sel = EvtIrqRegSet;
      end else if (off == AddrWidth'(EvtIrqModeOffset)) begin
         reg_sel = EvtIrqRegMode;
      end else if (off >= AddrWidth'(EvtIrqMaskBaseOffset) && mask_idx < AddrWidth'(NrCores)) begin
         reg_sel = EvtIrqRegMask;
      end
   end

   // Bits above NrEvents simply fall off here, so they read 0 and ignore writes.
   always_comb begin
      bitmask32 = strb_to_bitmask(strb_i);
      wdata_m   = wdata_i & bitmask32;
      bm        = bitmask32[NrEvents-1:0];
      wbits     = wdata_m[NrEvents-1:0];
      set_sw    = (wr_en && reg_sel == EvtIrqRegSet) ? wbits : '0;
      clr_sw    = (wr_en && reg_sel == EvtIrqRegPending) ? wbits : '0;
   end

   for (genvar e = 0; e < NrEvents; e++) begin : gen_evt
      tile_evt_edge_det i_edge_det (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .evt_i       (evt_i[e]),
         .edge_mode_i (mode_q[e]),
         .set_i       (set_sw[e]),
         .clr_i       (clr_sw[e]),
         .pending_o   (pending[e])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q <= ResetMode[NrEvents-1:0];
         for (int unsigned c = 0; c < NrCores; c++) begin
            mask_q[c] <= '0;
         end
      end else if (wr_en) begin
         if (reg_sel == EvtIrqRegMode) begin
            mode_q <= (mode_q & ~bm) | wbits;
         end
         for (int unsigned c = 0; c < NrCores; c++) begin
            if (reg_sel == EvtIrqRegMask && mask_idx == AddrWidth'(c)) begin
               mask_q[c] <= (mask_q[c] & ~bm) | wbits;
            end
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      unique case (reg_sel)
         EvtIrqRegPending: rdata_d = DataWidth'(pending);
         EvtIrqRegMode:    rdata_d = DataWidth'(mode_q);
         EvtIrqRegMask: begin
            for (int unsigned c = 0; c < NrCores; c++) begin
               if (mask_idx == AddrWidth'(c)) rdata_d = DataWidth'(mask_q[c]);
            end
         end
         default:          rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_o <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
         mxip_o   <= '0;
      end else begin
         rvalid_o <= req_i;
         err_o    <= req_i && (reg_sel == EvtIrqRegInvalid);
         rdata_o  <= (req_i && !we_i) ? rdata_d : '0;
         for (int unsigned c = 0; c < NrCores; c++) begin
            mxip_o[c] <= |(pending & mask_q[c]);
         end
      end
   end

endmodule

// File: tb/tb_tile_evt_irq_ctrl.sv
// Directed self-checking bench for tile_evt_irq_ctrl (default 9 cores, 4 events).
module tb_tile_evt_irq_ctrl;

   logic        clk, rst_n;
   logic [3:0]  evt;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  strb;
   logic        gnt, rvalid, err;
   logic [31:0] rdata;
   logic [8:0]  mxip;

   int n_checks = 0;
   int n_pass   = 0;

   tile_evt_irq_ctrl #(
      .NrCores   (9),
      .NrEvents  (4),
      .AddrWidth (32),
      .DataWidth (32),
      .ResetMode ('0)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .evt_i    (evt),
      .req_i    (req),
      .we_i     (we),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .strb_i   (strb),
      .gnt_o    (gnt),
      .rvalid_o (rvalid),
      .rdata_o  (rdata),
      .err_o    (err),
      .mxip_o   (mxip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // All bus tasks start and end at a falling edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; strb = s;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic e, output logic v);
      req = 1'b1; we = 1'b0; addr = a; strb = 4'h0;
      @(negedge clk);
      req = 1'b0;
      d = rdata; e = err; v = rvalid;
   endtask

   task automatic test_reset;
      logic [31:0] d; logic e, v;
      rst_n = 1'b0; evt = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; strb = '0;
      #3;
      n_checks++; if ({rvalid, err, rdata, mxip} !== '0) $display("FAIL reset_outputs: got rv=%b err=%b rdata=%h mxip=%h required all 0", rvalid, err, rdata, mxip); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_read(32'h08, d, e, v);
      n_checks++; if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) $display("FAIL reset_mode: got rv=%b err=%b data=%h required 1/0/0", v, e, d); else n_pass++;
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL reset_pending: got %h required 0", d); else n_pass++;
   endtask

   task automatic test_edge_irq;
      logic [31:0] d; logic e, v;
      bus_write(32'h08, 32'hF, 4'hF);
      bus_write(32'h18, 32'h2, 4'hF);
      bus_write(32'h00, 32'hF, 4'hF);
      repeat (2) @(negedge clk);
      n_checks++; if (mxip !== 9'h000) $display("FAIL edge_idle_mxip: got %h required 000", mxip); else n_pass++;
      evt = 4'h2;
      @(negedge clk);
      evt = 4'h0;
      n_checks++; if (mxip !== 9'h000) $display("FAIL edge_mxip_t1: got %h required 000", mxip); else n_pass++;
      @(negedge clk);
      n_checks++; if (mxip !== 9'h004) $display("FAIL edge_mxip_t2: got %h required 004", mxip); else n_pass++;
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h2) $display("FAIL edge_pending: got %h required 2", d); else n_pass++;
   endtask

   task automatic test_w1c_vs_edge;
      logic [31:0] d; logic e, v;
      evt = 4'h2;
      bus_write(32'h00, 32'h2, 4'hF);
      evt = 4'h0;
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h2) $display("FAIL set_beats_clear: got %h required 2", d); else n_pass++;
      bus_write(32'h00, 32'h2, 4'hF);
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL w1c_clear: got %h required 0", d); else n_pass++;
      @(negedge clk);
      n_checks++; if (mxip !== 9'h000) $display("FAIL w1c_mxip: got %h required 000", mxip); else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [31:0] d; logic e, v;
      bus_write(32'h04, 32'h5, 4'hF);
      req = 1'b1; we = 1'b0; addr = 32'h00;
      @(negedge clk);
      we = 1'b1; wdata = 32'h5; strb = 4'hF;
      n_checks++; if ({rvalid, rdata} !== {1'b1, 32'h5}) $display("FAIL b2b_read_preclear: got rv=%b data=%h required 1/5", rvalid, rdata); else n_pass++;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      n_checks++; if ({rvalid, err} !== 2'b10) $display("FAIL b2b_write_resp: got rv=%b err=%b required 1/0", rvalid, err); else n_pass++;
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL b2b_after_clear: got %h required 0", d); else n_pass++;
   endtask

   task automatic test_level;
      logic [31:0] d; logic e, v;
      bus_write(32'h08, 32'h0, 4'hF);
      bus_write(32'h10, 32'h1, 4'hF);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (mxip !== ((i >= 2 && i <= 6) ? 9'h001 : 9'h000))
            $display("FAIL level_mxip_%0d: got %h required %h", i, mxip, (i >= 2 && i <= 6) ? 9'h001 : 9'h000);
         else n_pass++;
         evt = (i < 5) ? 4'h1 : 4'h0;
         if (i == 2) begin
            req = 1'b1; we = 1'b1; addr = 32'h00; wdata = 32'h1; strb = 4'hF;
         end else begin
            req = 1'b0; we = 1'b0;
         end
         @(negedge clk);
      end
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL level_pending_follows: got %h required 0", d); else n_pass++;
   endtask

   task automatic test_decode_err;
      logic [31:0] d; logic e, v;
      req = 1'b1; we = 1'b0; addr = 32'h100; #1;
      n_checks++; if (gnt !== 1'b1) $display("FAIL gnt_comb: got %b required 1", gnt); else n_pass++;
      @(negedge clk);
      req = 1'b0; #1;
      n_checks++; if ({rvalid, err, rdata, gnt} !== {1'b1, 1'b1, 32'h0, 1'b0}) $display("FAIL err_read_0x100: got rv=%b err=%b data=%h gnt=%b required 1/1/0/0", rvalid, err, rdata, gnt); else n_pass++;
      @(negedge clk);
      bus_write(32'h0C, 32'hFFFF_FFFF, 4'hF);
      n_checks++; if ({rvalid, err} !== 2'b11) $display("FAIL err_write_0x0c: got rv=%b err=%b required 1/1", rvalid, err); else n_pass++;
      bus_read(32'h0B, d, e, v);
      n_checks++; if ({e, d} !== {1'b0, 32'h0}) $display("FAIL mode_unchanged_0x0b: got err=%b data=%h required 0/0", e, d); else n_pass++;
      bus_write(32'h04, 32'hF, 4'hF);
      bus_read(32'h04, d, e, v);
      n_checks++; if ({e, d} !== {1'b0, 32'h0}) $display("FAIL set_reads_zero: got err=%b data=%h required 0/0", e, d); else n_pass++;
   endtask

   task automatic test_set_strb;
      logic [31:0] d; logic e, v;
      bus_write(32'h08, 32'hF, 4'hF);
      bus_write(32'h00, 32'hF, 4'hF);
      bus_write(32'h04, 32'h9, 4'h1);
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h9) $display("FAIL set_strb1: got %h required 9", d); else n_pass++;
      bus_write(32'h00, 32'hF, 4'hF);
      bus_write(32'h04, 32'h9, 4'h0);
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL set_strb0: got %h required 0", d); else n_pass++;
      bus_write(32'h14, 32'hFFFF_FFFF, 4'h2);
      bus_read(32'h14, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL mask_lane1_only: got %h required 0", d); else n_pass++;
      bus_write(32'h14, 32'hFFFF_FFFF, 4'hF);
      bus_read(32'h14, d, e, v);
      n_checks++; if (d !== 32'hF) $display("FAIL mask_upper_bits: got %h required f", d); else n_pass++;
      bus_write(32'h30, 32'h3, 4'hF);
      bus_read(32'h30, d, e, v);
      n_checks++; if ({e, d} !== {1'b0, 32'h3}) $display("FAIL mask_last_core: got err=%b data=%h required 0/3", e, d); else n_pass++;
      bus_read(32'h34, d, e, v);
      n_checks++; if ({v, e, d} !== {1'b1, 1'b1, 32'h0}) $display("FAIL mask_past_end: got rv=%b err=%b data=%h required 1/1/0", v, e, d); else n_pass++;
   endtask

   task automatic test_reset_mid_req;
      logic [31:0] d; logic e, v;
      bus_write(32'h10, 32'hF, 4'hF);
      bus_write(32'h04, 32'hF, 4'hF);
      repeat (2) @(negedge clk);
      n_checks++; if (mxip !== 9'h107) $display("FAIL multi_core_mxip: got %h required 107", mxip); else n_pass++;
      req = 1'b1; we = 1'b0; addr = 32'h00;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({rvalid, err, rdata, mxip} !== '0) $display("FAIL async_reset_outputs: got rv=%b err=%b data=%h mxip=%h required all 0", rvalid, err, rdata, mxip); else n_pass++;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++; if (rvalid !== 1'b0) $display("FAIL stale_rvalid_%0d: got %b required 0", i, rvalid); else n_pass++;
      end
      bus_read(32'h00, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL pending_after_reset: got %h required 0", d); else n_pass++;
      bus_read(32'h08, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL mode_after_reset: got %h required 0", d); else n_pass++;
      bus_read(32'h10, d, e, v);
      n_checks++; if (d !== 32'h0) $display("FAIL mask0_after_reset: got %h required 0", d); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_edge_irq();
      test_w1c_vs_edge();
      test_back_to_back();
      test_level();
      test_decode_err();
      test_set_strb();
      test_reset_mid_req();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
